// File: rtl/wg_done_tracker.sv
// Workgroup completion tracker. Keeps a per-WG count of outstanding
// wavefronts, emits one done token when a WG finishes, and blocks
// re-dispatch of a WG ID until its token has been taken by the host.
module wg_done_tracker #(
  parameter int WG_ID_WIDTH  = 5,
  parameter int WF_CNT_WIDTH = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    dispatch_valid_i,
  output logic                    dispatch_ready_o,
  input  logic [WG_ID_WIDTH-1:0]  dispatch_wg_id_i,
  input  logic [WF_CNT_WIDTH-1:0] dispatch_wf_count_i,
  input  logic                    wf_done_valid_i,
  output logic                    wf_done_ready_o,
  input  logic [WG_ID_WIDTH-1:0]  wf_done_wg_id_i,
  output logic                    wg_done_valid_o,
  input  logic                    wg_done_ready_i,
  output logic [WG_ID_WIDTH-1:0]  wg_done_wg_id_o,
  output logic [WG_ID_WIDTH:0]    active_wg_cnt_o,
  output logic                    err_o
);
  localparam int DEPTH = 1 << WG_ID_WIDTH;

  logic [DEPTH-1:0]                   r_active;
  logic [DEPTH-1:0][WF_CNT_WIDTH-1:0] r_remain;
  logic                               r_out_vld;
  logic [WG_ID_WIDTH-1:0]             r_out_id;
  logic [WG_ID_WIDTH:0]               r_cnt;
  logic                               r_err;

  logic                    w_disp_acc, w_disp_load, w_disp_zero;
  logic                    w_wf_acc, w_wf_active, w_wf_dec, w_wf_err, w_cmpl;
  logic                    w_hs;
  logic [WF_CNT_WIDTH-1:0] w_wf_remain;
  logic [DEPTH-1:0]        w_load_sel, w_dec_sel, w_clr_sel;

  // A WG ID is only dispatchable once its previous incarnation is fully retired.
  assign dispatch_ready_o = ~r_active[dispatch_wg_id_i];
  // Any pending, unaccepted token stalls the whole wf_done stream.
  assign wf_done_ready_o  = ~r_out_vld | wg_done_ready_i;

  assign w_disp_acc  = dispatch_valid_i & dispatch_ready_o;
  assign w_disp_zero = (dispatch_wf_count_i == '0);
  assign w_disp_load = w_disp_acc & ~w_disp_zero;

  assign w_wf_acc    = wf_done_valid_i & wf_done_ready_o;
  assign w_wf_active = r_active[wf_done_wg_id_i];
  assign w_wf_remain = r_remain[wf_done_wg_id_i];
  // A WG whose count is already zero is waiting for its token; further wf_done is bogus.
  assign w_wf_dec    = w_wf_acc & w_wf_active & (w_wf_remain != '0);
  assign w_wf_err    = w_wf_acc & ~(w_wf_active & (w_wf_remain != '0));
  assign w_cmpl      = w_wf_dec & (w_wf_remain == WF_CNT_WIDTH'(1));

  assign w_hs        = r_out_vld & wg_done_ready_i;

  // One-hot row selects for the per-ID table update.
  always_comb begin
    w_load_sel = '0;
    w_dec_sel  = '0;
    w_clr_sel  = '0;
    w_load_sel[dispatch_wg_id_i] = w_disp_load;
    w_dec_sel[wf_done_wg_id_i]   = w_wf_dec;
    w_clr_sel[r_out_id]          = w_hs;
  end

  // Per-ID table: load on dispatch, decrement on wf_done, retire on token handshake.
  // A load and a decrement never hit the same row: loads need an inactive ID,
  // decrements need an active one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_active <= '0;
      r_remain <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_clr_sel[i])       r_active[i] <= 1'b0;
        if (w_load_sel[i]) begin
          r_active[i] <= 1'b1;
          r_remain[i] <= dispatch_wf_count_i;
        end else if (w_dec_sel[i]) begin
          r_remain[i] <= r_remain[i] - WF_CNT_WIDTH'(1);
        end
      end
    end
  end

  // Single-entry token register; a new completion may reload it on the handshake edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_vld <= 1'b0;
      r_out_id  <= '0;
    end else if (w_cmpl) begin
      r_out_vld <= 1'b1;
      r_out_id  <= wf_done_wg_id_i;
    end else if (w_hs) begin
      r_out_vld <= 1'b0;
    end
  end

  // Active-WG counter: up on activation, down on token handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_cnt <= '0;
    else begin
      case ({w_disp_load, w_hs})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Sticky protocol error: zero-count dispatch or wf_done for an ID with nothing outstanding.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                     r_err <= 1'b0;
    else if ((w_disp_acc & w_disp_zero) | w_wf_err) r_err <= 1'b1;
  end

  assign wg_done_valid_o = r_out_vld;
  assign wg_done_wg_id_o = r_out_id;
  assign active_wg_cnt_o = r_cnt;
  assign err_o           = r_err;
endmodule

// File: tb/tb_wg_done_tracker.sv
// Bench for wg_done_tracker: directed scenarios followed by randomized traffic,
// checked against a per-WG bookkeeping model and a token scoreboard.
module tb_wg_done_tracker;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       dispatch_valid_i = 1'b0;
  logic       dispatch_ready_o;
  logic [4:0] dispatch_wg_id_i = '0;
  logic [5:0] dispatch_wf_count_i = '0;
  logic       wf_done_valid_i = 1'b0;
  logic       wf_done_ready_o;
  logic [4:0] wf_done_wg_id_i = '0;
  logic       wg_done_valid_o;
  logic       wg_done_ready_i = 1'b0;
  logic [4:0] wg_done_wg_id_o;
  logic [5:0] active_wg_cnt_o;
  logic       err_o;

  wg_done_tracker #(.WG_ID_WIDTH(5), .WF_CNT_WIDTH(6)) dut (
    .clk(clk), .rst(rst),
    .dispatch_valid_i(dispatch_valid_i), .dispatch_ready_o(dispatch_ready_o),
    .dispatch_wg_id_i(dispatch_wg_id_i), .dispatch_wf_count_i(dispatch_wf_count_i),
    .wf_done_valid_i(wf_done_valid_i), .wf_done_ready_o(wf_done_ready_o),
    .wf_done_wg_id_i(wf_done_wg_id_i),
    .wg_done_valid_o(wg_done_valid_o), .wg_done_ready_i(wg_done_ready_i),
    .wg_done_wg_id_o(wg_done_wg_id_o), .active_wg_cnt_o(active_wg_cnt_o),
    .err_o(err_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit done = 0;

  // Reference model: which WGs are live, how many wavefronts each still owes,
  // whether a token is waiting for the host, live-WG count and error flag.
  bit m_active[32];
  int m_remain[32];
  bit m_tok;
  int m_tok_id;
  int m_cnt;
  bit m_err;
  int exp_q[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      m_active[i] = 0;
      m_remain[i] = 0;
    end
    m_tok = 0; m_tok_id = 0; m_cnt = 0; m_err = 0;
    exp_q.delete();
  endtask

  // One clock of stimulus: drive, check combinational/registered outputs, then
  // advance the model across the edge.
  task automatic cycle(input bit dv, input int did, input int dcnt,
                       input bit fv, input int fid, input bit hr);
    bit d_rdy, f_rdy, hs, dacc, facc, ferr, cmpl;
    @(negedge clk);
    dispatch_valid_i    = dv;
    dispatch_wg_id_i    = 5'(did);
    dispatch_wf_count_i = 6'(dcnt);
    wf_done_valid_i     = fv;
    wf_done_wg_id_i     = 5'(fid);
    wg_done_ready_i     = hr;
    #1;
    d_rdy = !m_active[did];
    f_rdy = !m_tok || hr;
    chk("dispatch_ready", dispatch_ready_o, d_rdy);
    chk("wf_done_ready", wf_done_ready_o, f_rdy);
    chk("wg_done_valid", wg_done_valid_o, m_tok);
    if (m_tok) chk("wg_done_id", wg_done_wg_id_o, m_tok_id);
    chk("active_cnt", active_wg_cnt_o, m_cnt);
    chk("err", err_o, m_err);
    hs   = m_tok && hr;
    dacc = dv && d_rdy;
    facc = fv && f_rdy;
    ferr = facc && !(m_active[fid] && m_remain[fid] > 0);
    cmpl = facc && !ferr && m_remain[fid] == 1;
    @(posedge clk);
    if (facc && !ferr) m_remain[fid]--;
    if (hs) begin
      m_active[m_tok_id] = 0;
      m_cnt--;
    end
    if (cmpl) begin
      m_tok = 1; m_tok_id = fid;
      exp_q.push_back(fid);
    end else if (hs) m_tok = 0;
    if (dacc) begin
      if (dcnt == 0) m_err = 1;
      else begin
        m_active[did] = 1;
        m_remain[did] = dcnt;
        m_cnt++;
      end
    end
    if (ferr) m_err = 1;
  endtask

  task automatic idle(input bit hr);
    cycle(0, 0, 1, 0, 0, hr);
  endtask

  // Asynchronous reset asserted between edges; outputs must clear at once.
  task automatic do_reset();
    @(negedge clk);
    dispatch_valid_i = 0; wf_done_valid_i = 0; wg_done_ready_i = 0;
    #3;
    rst = 1;
    #1;
    chk("rst_valid", wg_done_valid_o, 0);
    chk("rst_id", wg_done_wg_id_o, 0);
    chk("rst_cnt", active_wg_cnt_o, 0);
    chk("rst_err", err_o, 0);
    model_clear();
    @(negedge clk);
    rst = 0;
  endtask

  // Scoreboard monitor: each handshake the DUT presents must match the oldest expected token.
  initial begin
    int e;
    while (!done) begin
      @(negedge clk);
      #2;
      if (!rst && wg_done_valid_o && wg_done_ready_i) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL token_unexpected actual=%0d expected=none t=%0t", wg_done_wg_id_o, $time);
        end else begin
          e = exp_q.pop_front();
          chk("token_id", wg_done_wg_id_o, e);
        end
      end
    end
  end

  initial begin
    int act_ids[$];
    bit dv, fv, hr;
    int did, dcnt, fid;
    model_clear();
    #2;
    chk("init_valid", wg_done_valid_o, 0);
    chk("init_cnt", active_wg_cnt_o, 0);
    chk("init_err", err_o, 0);
    @(negedge clk);
    rst = 0;

    // Single WG of four wavefronts.
    cycle(1, 3, 4, 0, 0, 1);
    repeat (4) cycle(0, 0, 1, 1, 3, 0);
    idle(0); idle(1); idle(1);

    // Interleaved completions at the ID extremes.
    cycle(1, 0, 1, 0, 0, 1);
    cycle(1, 31, 2, 0, 0, 1);
    cycle(0, 0, 1, 1, 31, 1);
    cycle(0, 0, 1, 1, 0, 1);
    cycle(0, 0, 1, 1, 31, 1);
    idle(1); idle(1);

    // Host back-pressure stalls wf_done for every ID.
    cycle(1, 1, 1, 0, 0, 0);
    cycle(1, 2, 1, 0, 0, 0);
    cycle(0, 0, 1, 1, 1, 0);
    cycle(0, 0, 1, 1, 2, 0);
    cycle(0, 0, 1, 1, 2, 0);
    cycle(0, 0, 1, 1, 2, 1);
    idle(1); idle(1);

    // Re-dispatch blocked until the handshake edge, then accepted.
    cycle(1, 3, 2, 0, 0, 0);
    cycle(1, 3, 2, 1, 3, 0);
    cycle(1, 3, 2, 1, 3, 0);
    cycle(1, 3, 2, 0, 0, 0);
    cycle(1, 3, 2, 0, 0, 1);
    cycle(1, 3, 2, 0, 0, 1);
    cycle(0, 0, 1, 1, 3, 1);
    cycle(0, 0, 1, 1, 3, 1);
    idle(1); idle(1);

    // Protocol errors: stray wf_done, then zero-count dispatch.
    cycle(0, 0, 1, 1, 7, 1);
    idle(1);
    cycle(1, 9, 0, 0, 0, 1);
    cycle(1, 9, 1, 0, 0, 1);
    cycle(0, 0, 1, 1, 9, 1);
    idle(1); idle(1);

    // Reset with live WGs and a pending token; stale wf_done then errors.
    do_reset();
    cycle(1, 10, 2, 0, 0, 0);
    cycle(1, 11, 2, 0, 0, 0);
    cycle(1, 12, 2, 1, 10, 0);
    cycle(0, 0, 1, 1, 10, 0);
    idle(0);
    do_reset();
    cycle(0, 0, 1, 1, 11, 1);
    idle(1);
    do_reset();

    // Randomized traffic over a small hot ID range to force collisions.
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) do_reset();
      dv   = ($urandom_range(0, 1) == 1);
      did  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 7));
      dcnt = ($urandom_range(0, 19) == 0) ? 0 : int'($urandom_range(1, 4));
      if ($urandom_range(0, 49) == 0) dcnt = 63;
      fv   = ($urandom_range(0, 9) < 7);
      act_ids.delete();
      for (int i = 0; i < 32; i++) if (m_active[i] && m_remain[i] > 0) act_ids.push_back(i);
      if (act_ids.size() == 0 || $urandom_range(0, 19) == 0) fid = int'($urandom_range(0, 31));
      else fid = act_ids[$urandom_range(0, act_ids.size() - 1)];
      hr   = ($urandom_range(0, 9) < 6);
      cycle(dv, did, dcnt, fv, fid, hr);
    end
    idle(1); idle(1);

    done = 1;
    @(negedge clk);
    #5;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
